// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage hazard sequencing for load-use, taken branches and multi-cycle multiplies.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W = 3,
  parameter int PERF_W = 16
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [4:0]        IFID_Rs,
  input  logic [4:0]        IFID_Rt,
  input  logic              IFID_UsesRt,
  input  logic              IDEX_MemRead,
  input  logic [4:0]        IDEX_Rt,
  input  logic              ID_MulStart,
  input  logic              EX_BranchTaken,
  output logic              PC_Write,
  output logic              IFID_Write,
  output logic              IFID_Flush,
  output logic              IDEX_Bubble,
  output logic              Mul_Busy,
  output logic [PERF_W-1:0] Stall_Total
);
  typedef enum logic [1:0] {RUN, MUL_WAIT, MUL_RELEASE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;
  logic load_use, stall;
  assign load_use = IDEX_MemRead && IDEX_Rt != 5'd0 &&
                    (IDEX_Rt == IFID_Rs || (IFID_UsesRt && IDEX_Rt == IFID_Rt));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    stall = 1'b0;
    IFID_Flush = 1'b0;
    if (Rst) begin
      state_d = RUN;
      cnt_d = '0;
      stall = 1'b1;
      IFID_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      state_d = RUN;
      cnt_d = '0;
      IFID_Flush = 1'b1;
    end else if (state_q == MUL_WAIT) begin
      stall = 1'b1;
      state_d = cnt_q == '0 ? MUL_RELEASE : MUL_WAIT;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
    end else if (load_use) begin
      stall = 1'b1;
    end else if (state_q == RUN && ID_MulStart) begin
      stall = 1'b1;
      state_d = MUL_WAIT;
      cnt_d = CNT_W'(MUL_CYCLES - 2);
    end else begin
      state_d = RUN;
    end
    PC_Write = ~stall;
    IFID_Write = ~stall;
    IDEX_Bubble = stall | IFID_Flush;
    Mul_Busy = ~Rst && state_q == MUL_WAIT;
    stall_d = Rst ? '0 : (stall && ~&stall_q) ? stall_q + 1'b1 : stall_q;
  end
  always_ff @(posedge Clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    stall_q <= stall_d;
  end
  assign Stall_Total = stall_q;
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller that sequences the IF/ID pipeline register and the PC for the 5-stage MIPS core.
- Detects load-use hazards, taken-branch control hazards and multi-cycle multiply occupancy in ID.
- Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble select.
- Sits beside the ID stage, between the IFID register and the IDEX register.

Parameters:
- MUL_CYCLES, 4, total stall cycles a multiply holds in ID (legal range 2..7).
- CNT_W, 3, width of the multiply countdown counter (must hold MUL_CYCLES-1).
- PERF_W, 16, width of the saturating stall-cycle counter.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Rst  in  1  synchronous reset, active-high.
- IFID_Rs  in  5  rs field of the instruction in ID.
- IFID_Rt  in  5  rt field of the instruction in ID.
- IFID_UsesRt  in  1  instruction in ID reads rt as a source.
- IDEX_MemRead  in  1  instruction in EX is a load.
- IDEX_Rt  in  5  destination register of the load in EX.
- ID_MulStart  in  1  instruction in ID is a multiply.
- EX_BranchTaken  in  1  branch in EX resolved taken.
- PC_Write  out  1  PC load enable.
- IFID_Write  out  1  IF/ID register load enable.
- IFID_Flush  out  1  IF/ID register loads a NOP (IR=0).
- IDEX_Bubble  out  1  ID/EX register loads control zeros.
- Mul_Busy  out  1  high while in MUL_WAIT.
- Stall_Total  out  PERF_W  saturating count of cycles with PC_Write=0.

Behaviour:
- States: RUN, MUL_WAIT, MUL_RELEASE. Control outputs are Mealy, combinational from state and inputs in the same cycle. Counters and state are registered.
- Rst high, checked at the rising edge:
  - Next state RUN; countdown cleared to 0; Stall_Total cleared to 0.
  - While Rst is high: PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, Mul_Busy=0.
- load_use = IDEX_MemRead & (IDEX_Rt!=0) & ((IDEX_Rt==IFID_Rs) | (IFID_UsesRt & (IDEX_Rt==IFID_Rt))).
- Priority in every state: EX_BranchTaken > load_use > multiply.
- Default outputs: PC_Write=1, IFID_Write=1, IFID_Flush=0, IDEX_Bubble=0.
- EX_BranchTaken, in any state:
  - Outputs: IFID_Flush=1, IDEX_Bubble=1, PC_Write=1, IFID_Write=1.
  - Next state RUN; countdown cleared. This aborts MUL_WAIT, because the multiply in ID is younger than the branch.
- load_use, branch not taken, in RUN or MUL_RELEASE:
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - State unchanged. The hazard clears the next cycle once the load leaves EX (exactly 1 stall cycle).
- RUN with ID_MulStart, no branch and no load_use:
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Bubble=1.
  - Countdown loads MUL_CYCLES-2; next state MUL_WAIT.
- MUL_WAIT, no branch:
  - Outputs: PC_Write=0, IFID_Write=0, IDEX_Bubble=1; Mul_Busy=1.
  - Countdown decrements each cycle. When the countdown is 0, next state MUL_RELEASE.
  - load_use is not evaluated in MUL_WAIT.
- MUL_RELEASE:
  - ID_MulStart is ignored, so the held multiply proceeds once with default outputs.
  - Next state RUN.
  - Total multiply stall is exactly MUL_CYCLES cycles.
- Stall_Total increments by 1 on every non-reset cycle with PC_Write=0 and saturates at all-ones.
- Load-use against $0 never stalls.

Test Plan:
- Rst=1 for 2 cycles, then release with no hazards:
  - During reset: PC_Write=0, IFID_Flush=1, IDEX_Bubble=1.
  - After release: PC_Write=1, IFID_Write=1, Stall_Total=0.
- IDEX_MemRead=1, IDEX_Rt=8, IFID_Rs=8 for one cycle:
  - 1 cycle with PC_Write=0, IFID_Write=0, IDEX_Bubble=1, then normal; Stall_Total=1.
  - Repeat with IDEX_Rt=0, IFID_Rs=0: no stall.
  - Repeat with IFID_Rt=8, IFID_UsesRt=0: no stall.
- ID_MulStart held high, MUL_CYCLES=4:
  - PC_Write=0 for exactly 4 consecutive cycles; Mul_Busy=1 for 3 of them.
  - 5th cycle PC_Write=1 with ID_MulStart still high (release).
  - Stall_Total=4.
- Multiply in MUL_WAIT (2nd stall cycle), EX_BranchTaken=1:
  - Same cycle: IFID_Flush=1, PC_Write=1, IDEX_Bubble=1.
  - Next cycle: state RUN, Mul_Busy=0.
- EX_BranchTaken=1 and load_use=1 together:
  - Branch wins: IFID_Flush=1, PC_Write=1, no stall counted.
- Rst asserted during MUL_WAIT:
  - Next cycle: state RUN, Mul_Busy=0, Stall_Total=0.
- Force 70000 stall cycles with PERF_W=16:
  - Stall_Total saturates at 65535.
